// File: rtl/digit_history_pkg.sv
// Shared widths, FSM states and seven-segment patterns for the digit history viewer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package digit_history_pkg;

   localparam int DIGIT_W = 4;
   localparam int SEG_W   = 7;

   typedef enum logic [1:0] {
      MAIN  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2
   } state_t;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;

   // Any digit code above 9 renders blank; this one is used for empty window slots.
   localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 4'hF;

endpackage

// File: rtl/seg7_digit_encoder.sv
// Converts one 4-bit digit into an active-low seven-segment pattern; non-decimal codes blank.
// Latency: purely combinational.
// Backpressure: none.
module seg7_digit_encoder
   import digit_history_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [SEG_W-1:0]   seg
);

   // Digit-to-segment lookup
   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/digit_history_viewer.sv
// Digit entry with a bounded history, a scrolling seven-segment window, auto-play and undo.
// Latency: every event updates registers on the sampling edge; outputs follow one cycle after the pulse.
// Backpressure: none; inputs are pulses and a held-high input acts once per cycle.
module digit_history_viewer
   import digit_history_pkg::*;
#(
   parameter int CHOICE_WIDTH  = 7,
   parameter int BASE_DIGIT    = 3,
   parameter int HISTORY_DEPTH = 16,
   parameter int DISPLAY_NUM   = 4,
   parameter int TICK_CYCLES   = 50_000_000
)
(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [CHOICE_WIDTH-1:0]                digit_choice,
   input  logic                                   digit_load,
   input  logic                                   digit_undo,
   input  logic                                   digit_change,
   input  logic                                   mode_change,
   output logic [SEG_W*DISPLAY_NUM-1:0]           display,
   output logic                                   digit_load_indicator,
   output logic [$clog2(HISTORY_DEPTH+1)-1:0]     history_size,
   output logic                                   playing
);

   localparam int SIZE_W = $clog2(HISTORY_DEPTH + 1);
   localparam int IDX_W  = $clog2(HISTORY_DEPTH);
   localparam int TMR_W  = $clog2(TICK_CYCLES);
   localparam logic [SIZE_W-1:0] SIZE_MAX = SIZE_W'(HISTORY_DEPTH);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TICK_CYCLES - 1);

   state_t                    state_q, state_d;
   logic [SIZE_W-1:0]         size_q, size_d;
   logic [SIZE_W-1:0]         idx_q, idx_d;
   logic [TMR_W-1:0]          timer_q, timer_d;
   logic                      ind_q, ind_d;
   logic [CHOICE_WIDTH-1:0]   cap_q, cap_d;
   logic [DIGIT_W-1:0]        hist_q [HISTORY_DEPTH];
   logic [DIGIT_W-1:0]        enc_digit;
   logic                      push;
   logic                      pop;

   // Window step: move one slot deeper, wrapping to the newest once past the valid entries.
   function automatic logic [SIZE_W-1:0] wrap_next(input logic [SIZE_W-1:0] idx,
                                                   input logic [SIZE_W-1:0] size);
      logic [SIZE_W:0] inc;
      inc = {1'b0, idx} + (SIZE_W+1)'(1);
      return (inc >= {1'b0, size}) ? '0 : inc[SIZE_W-1:0];
   endfunction

   // Highest set choice bit selects the digit; later iterations override lower bits.
   always_comb begin
      enc_digit = '0;
      for (int i = 0; i < CHOICE_WIDTH; i++) begin
         if (digit_choice[i]) enc_digit = DIGIT_W'(BASE_DIGIT + i);
      end
   end

   // Next-state for FSM, counters and indicator; only the highest-priority pulse acts.
   always_comb begin
      state_d = state_q;
      size_d  = size_q;
      idx_d   = idx_q;
      timer_d = timer_q;
      ind_d   = ind_q;
      cap_d   = cap_q;
      push    = 1'b0;
      pop     = 1'b0;

      // Auto-scroll timer runs whenever the registered state is PLAY.
      if (state_q == PLAY) begin
         if (timer_q == TMR_LAST) begin
            timer_d = '0;
            idx_d   = wrap_next(idx_q, size_q);
         end else begin
            timer_d = timer_q + TMR_W'(1);
         end
      end

      // Indicator drops once the operator moves off the loaded choice; a load below re-arms it.
      if (state_q == MAIN && digit_choice != cap_q) ind_d = 1'b0;

      if (mode_change) begin
         state_d = (state_q == MAIN) ? PLAY : MAIN;
         idx_d   = '0;
         timer_d = '0;
         ind_d   = 1'b0;
      end else if (digit_load) begin
         if (state_q == MAIN && digit_choice != '0) begin
            push   = 1'b1;
            size_d = (size_q == SIZE_MAX) ? size_q : size_q + SIZE_W'(1);
            idx_d  = '0;
            ind_d  = 1'b1;
            cap_d  = digit_choice;
         end
      end else if (digit_undo) begin
         if (state_q == MAIN && size_q != '0) begin
            pop    = 1'b1;
            size_d = size_q - SIZE_W'(1);
            idx_d  = '0;
            ind_d  = 1'b0;
         end
      end else if (digit_change) begin
         case (state_q)
            MAIN:    idx_d   = wrap_next(idx_q, size_q);
            PLAY:    state_d = PAUSE;
            PAUSE:   state_d = PLAY;
            default: state_d = MAIN;
         endcase
      end
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MAIN;
         size_q  <= '0;
         idx_q   <= '0;
         timer_q <= '0;
         ind_q   <= 1'b0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         idx_q   <= idx_d;
         timer_q <= timer_d;
         ind_q   <= ind_d;
         cap_q   <= cap_d;
      end
   end

   // History shift array: push inserts at slot 0 (oldest falls off), pop drops slot 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < HISTORY_DEPTH; i++) hist_q[i] <= '0;
      end else if (push) begin
         hist_q[0] <= enc_digit;
         for (int i = 1; i < HISTORY_DEPTH; i++) hist_q[i] <= hist_q[i-1];
      end else if (pop) begin
         for (int i = 0; i < HISTORY_DEPTH - 1; i++) hist_q[i] <= hist_q[i+1];
      end
   end

   // Window positions: slot index+k when it holds a valid entry, otherwise blank.
   for (genvar k = 0; k < DISPLAY_NUM; k++) begin : g_pos
      logic [SIZE_W:0]    slot;
      logic [DIGIT_W-1:0] digit;
      assign slot  = {1'b0, idx_q} + (SIZE_W+1)'(k);
      assign digit = (slot < {1'b0, size_q}) ? hist_q[slot[IDX_W-1:0]] : DIGIT_BLANK;
      seg7_digit_encoder u_enc (
         .digit (digit),
         .seg   (display[SEG_W*k +: SEG_W])
      );
   end

   assign digit_load_indicator = ind_q;
   assign history_size         = size_q;
   assign playing              = (state_q == PLAY);

endmodule

// File: tb/tb_digit_history_viewer.sv
// Directed bench for digit_history_viewer (depth 4, two positions, 3-cycle tick) with a scoreboard.
// Latency: expectations are queued one edge after each stimulus cycle and checked on the next falling edge.
// Backpressure: none; the monitor drains the queue every falling edge.
module tb_digit_history_viewer;

   localparam logic [6:0] SB = 7'b1111111;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;

   typedef struct {
      string       name;
      logic [13:0] disp;
      logic        ind;
      logic [2:0]  size;
      logic        play;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  digit_choice;
   logic        digit_load;
   logic        digit_undo;
   logic        digit_change;
   logic        mode_change;
   logic [13:0] display;
   logic        digit_load_indicator;
   logic [2:0]  history_size;
   logic        playing;

   exp_t sb_q [$];
   int   checks = 0;
   int   errors = 0;

   digit_history_viewer #(
      .CHOICE_WIDTH  (7),
      .BASE_DIGIT    (3),
      .HISTORY_DEPTH (4),
      .DISPLAY_NUM   (2),
      .TICK_CYCLES   (3)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .digit_choice         (digit_choice),
      .digit_load           (digit_load),
      .digit_undo           (digit_undo),
      .digit_change         (digit_change),
      .mode_change          (mode_change),
      .display              (display),
      .digit_load_indicator (digit_load_indicator),
      .history_size         (history_size),
      .playing              (playing)
   );

   always #5 clk = ~clk;

   // Monitor: compare every pending expectation against the outputs, away from the rising edge.
   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         checks++;
         if (display !== e.disp || digit_load_indicator !== e.ind ||
             history_size !== e.size || playing !== e.play) begin
            errors++;
            $display("FAIL %s: got disp=%b ind=%b size=%0d play=%b, want disp=%b ind=%b size=%0d play=%b",
                     e.name, display, digit_load_indicator, history_size, playing,
                     e.disp, e.ind, e.size, e.play);
         end
      end
   end

   task automatic cyc(input logic ld, input logic ud, input logic ch, input logic md);
      digit_load   = ld;
      digit_undo   = ud;
      digit_change = ch;
      mode_change  = md;
      @(posedge clk);
      #1;
      digit_load   = 1'b0;
      digit_undo   = 1'b0;
      digit_change = 1'b0;
      mode_change  = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [6:0] p1, input logic [6:0] p0,
                             input logic ind, input logic [2:0] sz, input logic pl);
      exp_t e;
      e.name = name;
      e.disp = {p1, p0};
      e.ind  = ind;
      e.size = sz;
      e.play = pl;
      sb_q.push_back(e);
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      digit_choice = '0;
      digit_load = 1'b0;
      digit_undo = 1'b0;
      digit_change = 1'b0;
      mode_change = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_out("reset", SB, SB, 0, 0, 0);

      // Loads: 0000001->3, 0000100->5, 1000000->9
      digit_choice = 7'b0000001; cyc(1,0,0,0); expect_out("load3", SB, S3, 1, 1, 0);
      digit_choice = 7'b0000100; cyc(1,0,0,0); expect_out("load5", S3, S5, 1, 2, 0);
      digit_choice = 7'b1000000; cyc(1,0,0,0); expect_out("load9", S5, S9, 1, 3, 0);
      digit_choice = 7'b0000010; cyc(0,0,0,0); expect_out("ind_clear", S5, S9, 0, 3, 0);
      digit_choice = 7'b0000000; cyc(1,0,0,0); expect_out("load_zero", S5, S9, 0, 3, 0);

      // Manual stepping over 3 entries
      cyc(0,0,1,0); expect_out("step_idx1", S3, S5, 0, 3, 0);
      cyc(0,0,1,0); expect_out("step_idx2", SB, S3, 0, 3, 0);
      cyc(0,0,1,0); expect_out("step_wrap", S5, S9, 0, 3, 0);

      // Playback: first step three cycles after entry
      cyc(0,0,0,1); expect_out("play_enter", S5, S9, 0, 3, 1);
      cyc(0,0,0,0); expect_out("play_t1", S5, S9, 0, 3, 1);
      cyc(0,0,0,0); expect_out("play_t2", S5, S9, 0, 3, 1);
      cyc(0,0,0,0); expect_out("play_tick1", S3, S5, 0, 3, 1);
      cyc(0,0,0,0);
      cyc(0,0,1,0); expect_out("pause", S3, S5, 0, 3, 0);
      repeat (3) cyc(0,0,0,0);
      expect_out("pause_hold", S3, S5, 0, 3, 0);
      cyc(0,0,1,0); expect_out("resume", S3, S5, 0, 3, 1);
      cyc(0,0,0,0); expect_out("resume_tick", SB, S3, 0, 3, 1);
      repeat (3) cyc(0,0,0,0);
      expect_out("play_wrap", S5, S9, 0, 3, 1);
      cyc(0,0,0,1); expect_out("back_main", S5, S9, 0, 3, 0);

      // Overflow of depth 4: 3 is discarded
      digit_choice = 7'b0001000; cyc(1,0,0,0); expect_out("load6_full", S9, S6, 1, 4, 0);
      digit_choice = 7'b0010000; cyc(1,0,0,0); expect_out("load7_drop", S6, S7, 1, 4, 0);
      repeat (3) cyc(0,0,1,0);
      expect_out("oldest_idx3", SB, S5, 1, 4, 0);
      cyc(0,0,1,0); expect_out("full_wrap", S6, S7, 1, 4, 0);

      // Undo down to empty and one extra
      cyc(0,1,0,0); expect_out("undo_4to3", S9, S6, 0, 3, 0);
      cyc(0,1,0,0); expect_out("undo_3to2", S5, S9, 0, 2, 0);
      cyc(0,1,0,0); expect_out("undo_2to1", SB, S5, 0, 1, 0);
      cyc(0,1,0,0); expect_out("undo_1to0", SB, SB, 0, 0, 0);
      cyc(0,1,0,0); expect_out("undo_empty", SB, SB, 0, 0, 0);

      // mode_change beats digit_load; loads ignored in PLAY
      digit_choice = 7'b0000001;
      cyc(1,0,0,1); expect_out("mode_over_load", SB, SB, 0, 0, 1);
      cyc(1,0,0,0); expect_out("load_in_play", SB, SB, 0, 0, 1);
      cyc(0,0,0,1); expect_out("main_again", SB, SB, 0, 0, 0);
      cyc(1,0,0,0); expect_out("reload3", SB, S3, 1, 1, 0);
      cyc(0,0,0,1); expect_out("play_again", SB, S3, 0, 1, 1);

      // Reset mid-PLAY overrides a simultaneous event
      rst = 1'b1;
      cyc(0,0,1,0);
      rst = 1'b0;
      expect_out("rst_mid_play", SB, SB, 0, 0, 0);
      cyc(0,0,0,0); expect_out("post_rst_idle", SB, SB, 0, 0, 0);

      guard = 0;
      while (sb_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
      end
      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/digit_history_viewer.md
# digit_history_viewer

Parametrised digit-entry and history-playback block for the seven-segment board designs. It accepts a priority-encoded digit choice, keeps a depth-configurable history of loaded digits, and drives a multi-digit seven-segment window over that history. It supports manual stepping, timed auto-scroll with pause, and undo of the newest entry. It sits between the debounced/edge-detected board inputs and the display pins.

## Interface
- CHOICE_WIDTH, 7: width of digit_choice; highest set bit i selects digit BASE_DIGIT+i.
- BASE_DIGIT, 3: digit value of bit 0; BASE_DIGIT+CHOICE_WIDTH-1 must be ≤ 9.
- HISTORY_DEPTH, 16: number of stored digits (≥ 2).
- DISPLAY_NUM, 4: seven-segment positions shown at once (1..HISTORY_DEPTH).
- TICK_CYCLES, 50_000_000: clk cycles per auto-scroll step (≥ 2).
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- digit_choice  in  CHOICE_WIDTH  level input, priority-encoded.
- digit_load  in  1  one-cycle pulse: push the encoded digit.
- digit_undo  in  1  one-cycle pulse: drop the newest digit.
- digit_change  in  1  one-cycle pulse: step the window (MAIN) or toggle pause (PLAY/PAUSE).
- mode_change  in  1  one-cycle pulse: MAIN ↔ playback.
- display  out  7*DISPLAY_NUM  position k at [7k+6:7k], {g,f,e,d,c,b,a}, active-low.
- digit_load_indicator  out  1  high after a successful load until the choice changes.
- history_size  out  $clog2(HISTORY_DEPTH+1)  number of valid entries.
- playing  out  1  high in PLAY state only.

## Operation
- History: a shift array of 4-bit digits. Slot 0 holds the newest digit. Entries at slot ≥ size are don't-care.
- Window: index register. Position k shows slot index+k if index+k < size; otherwise it is blank (7'b1111111).
- Encoding: digits 0–9 use the standard active-low patterns, e.g. 0=1000000, 3=0110000, 5=0010010, 7=1111000, 9=0010000. Any other value is blank.
- States: MAIN, PLAY, PAUSE.
- Event priority in one cycle: mode_change > digit_load > digit_undo > digit_change. Only the highest-priority event acts; the others are dropped.
- mode_change:
  - MAIN→PLAY; PLAY or PAUSE→MAIN.
  - Always clears index and timer, and clears the indicator.
- digit_load (MAIN only; ignored in PLAY/PAUSE):
  - If digit_choice == 0: no effect.
  - Otherwise shift the history up, write the digit to slot 0, and set size = min(size+1, HISTORY_DEPTH). When full, the oldest entry is discarded.
  - Clear index, set the indicator, and capture digit_choice.
- digit_undo (MAIN only):
  - If size == 0: no effect.
  - Otherwise shift the history down, size−1, clear index, clear the indicator.
- digit_change:
  - MAIN: index = (index+1 ≥ size) ? 0 : index+1. With size 0, index stays 0.
  - PLAY→PAUSE; PAUSE→PLAY. The timer keeps its value across pause.
- Timer:
  - Counts only in PLAY, from 0 to TICK_CYCLES−1.
  - On reaching TICK_CYCLES−1, the next edge resets it to 0 and advances index with the same wrap rule as MAIN.
- Indicator: cleared in MAIN when digit_choice differs from the captured value. A simultaneous load still sets it (load wins).

## Timing
- Reset values: state MAIN, size 0, index 0, timer 0, indicator 0, captured choice 0. Outputs: display all 7'b1111111, digit_load_indicator 0, history_size 0, playing 0.
- rst overrides every event in the same cycle and clears the block mid-playback.
- All registers update on the edge that samples the event. Outputs are combinational from registers, so they are visible one cycle after the event pulse.
- In PLAY, a step occurs every TICK_CYCLES cycles; the first step is TICK_CYCLES cycles after entry.
- A mode_change on the same edge as a tick wins: there is no index advance, and index becomes 0.
- No ready/valid handshake. Inputs are pulses; held-high inputs act once per cycle.

## Structure
- Package digit_history_pkg holds:
  - digit width (4) and segment width (7);
  - the state enum (MAIN/PLAY/PAUSE);
  - the SEG_BLANK and digit segment constants.
- Sub-module seg7_digit_encoder (4-bit in, 7-bit active-low out) is instantiated DISPLAY_NUM times.
- Priority encoder, history array, index/size/timer counters and FSM live in the top module.

## Test plan
Run with HISTORY_DEPTH=4, DISPLAY_NUM=2, TICK_CYCLES=3.
- Reset, then load choices 0000001, 0000100, 1000000 → history_size=3; display pos0=9 (0010000), pos1=5 (0010010); indicator=1.
- Load 5 digits into depth 4 → history_size stays 4; the oldest digit is dropped; pos0 shows the newest.
- Change digit_choice after a load → indicator goes 0 next cycle. Load with choice 0 → no change to any state.
- size=3, then digit_change ×3 → index 1, 2, 0. At index 2, pos1 is blank.
- mode_change → playing=1; index advances every 3 cycles. digit_change pauses and index holds. digit_change again resumes from the saved timer.
- Undo ×4 with size 3 → size 3→2→1→0→0; display all blank. mode_change and digit_load on the same cycle → only the state toggles; size is unchanged. rst mid-PLAY → all reset values.
